// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: control priority
// encoding, default step/reset constants and the RAS count-width helper.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_RET,
        PC_CALL,
        PC_BRANCH,
        PC_REL,
        PC_SEQ
    } pc_sel_e;

    localparam int DEFAULT_STEP       = 4;
    localparam int DEFAULT_RESET_ADDR = 0;

    // One extra bit so the count can represent a completely full stack.
    function automatic int ras_count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Circular return-address stack: a full push overwrites the oldest entry,
// an empty pop leaves state alone; both report a one-cycle event.
module pc_return_stack
    import pc_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int RAS_DEPTH  = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   push,
    input  logic                                   pop,
    input  logic [ADDR_WIDTH-1:0]                  push_data,
    output logic [ADDR_WIDTH-1:0]                  top_data,
    output logic [ras_count_width(RAS_DEPTH)-1:0]  count,
    output logic                                   empty,
    output logic                                   overflow_event,
    output logic                                   underflow_event
);

    localparam int CNT_W = ras_count_width(RAS_DEPTH);
    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [ADDR_WIDTH-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]      top_ptr;
    logic                  full;

    assign full            = (count == CNT_W'(RAS_DEPTH));
    assign empty           = (count == '0);
    assign overflow_event  = push && full;
    assign underflow_event = pop && !push && empty;
    assign top_data        = mem[top_ptr];

    // The pointer wraps naturally because the depth is a power of two, so a
    // push into a full stack lands on the oldest entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            top_ptr <= '0;
            count   <= '0;
        end else if (push) begin
            top_ptr <= top_ptr + PTR_W'(1);
            if (!full) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            top_ptr <= top_ptr - PTR_W'(1);
            count   <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[top_ptr + PTR_W'(1)] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side program counter: prioritised next-address mux (ret > call >
// branch > relative > sequential), return-address stack and sticky flags.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int STEP       = DEFAULT_STEP,
    parameter int RESET_ADDR = DEFAULT_RESET_ADDR,
    parameter int RAS_DEPTH  = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   enable,
    input  logic                                   branch_valid,
    input  logic [ADDR_WIDTH-1:0]                  branch_target,
    input  logic                                   rel_valid,
    input  logic [ADDR_WIDTH-1:0]                  rel_offset,
    input  logic                                   call,
    input  logic                                   ret,
    input  logic                                   clear_flags,
    output logic [ADDR_WIDTH-1:0]                  address,
    output logic [ADDR_WIDTH-1:0]                  next_address,
    output logic [ras_count_width(RAS_DEPTH)-1:0]  ras_count,
    output logic                                   ras_overflow,
    output logic                                   ras_underflow
);

    localparam logic [ADDR_WIDTH-1:0] STEP_W  = ADDR_WIDTH'(STEP);
    localparam logic [ADDR_WIDTH-1:0] RESET_W = ADDR_WIDTH'(RESET_ADDR);

    pc_sel_e               sel;
    logic [ADDR_WIDTH-1:0] seq_address;
    logic [ADDR_WIDTH-1:0] top_data;
    logic                  ras_empty;
    logic                  push;
    logic                  pop;
    logic                  overflow_event;
    logic                  underflow_event;

    assign seq_address = address + STEP_W;

    always_comb begin
        sel = PC_SEQ;
        if (ret) begin
            sel = PC_RET;
        end else if (call) begin
            sel = PC_CALL;
        end else if (branch_valid) begin
            sel = PC_BRANCH;
        end else if (rel_valid) begin
            sel = PC_REL;
        end
    end

    // A return on an empty stack falls back to the sequential address.
    always_comb begin
        next_address = seq_address;
        case (sel)
            PC_RET:    next_address = ras_empty ? seq_address : top_data;
            PC_CALL:   next_address = branch_target;
            PC_BRANCH: next_address = branch_target;
            PC_REL:    next_address = address + rel_offset;
            PC_SEQ:    next_address = seq_address;
            default:   next_address = seq_address;
        endcase
    end

    assign push = enable && (sel == PC_CALL);
    assign pop  = enable && (sel == PC_RET);

    pc_return_stack #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAS_DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk             (clk),
        .reset           (reset),
        .push            (push),
        .pop             (pop),
        .push_data       (seq_address),
        .top_data        (top_data),
        .count           (ras_count),
        .empty           (ras_empty),
        .overflow_event  (overflow_event),
        .underflow_event (underflow_event)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            address <= RESET_W;
        end else if (enable) begin
            address <= next_address;
        end
    end

    // A new event in the same cycle as clear_flags leaves the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            ras_overflow  <= overflow_event  || (ras_overflow  && !clear_flags);
            ras_underflow <= underflow_event || (ras_underflow && !clear_flags);
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a queue-based reference model and
// an expected-result scoreboard checked one cycle after each drive.
module tb_pc_sequencer;

    localparam int W   = 32;
    localparam int CW  = 3;
    localparam int OBS = W + CW + 2;

    logic          clk;
    logic          reset;
    logic          enable;
    logic          branch_valid;
    logic [W-1:0]  branch_target;
    logic          rel_valid;
    logic [W-1:0]  rel_offset;
    logic          call;
    logic          ret;
    logic          clear_flags;
    logic [W-1:0]  address;
    logic [W-1:0]  next_address;
    logic [CW-1:0] ras_count;
    logic          ras_overflow;
    logic          ras_underflow;

    pc_sequencer #(
        .ADDR_WIDTH (32),
        .STEP       (4),
        .RESET_ADDR (0),
        .RAS_DEPTH  (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .rel_valid     (rel_valid),
        .rel_offset    (rel_offset),
        .call          (call),
        .ret           (ret),
        .clear_flags   (clear_flags),
        .address       (address),
        .next_address  (next_address),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    int n_pass = 0;
    int n_fail = 0;

    logic [OBS-1:0] exp_q[$];
    string          tag_q[$];

    // reference model: stack as a queue, oldest entry at the front
    logic [W-1:0] m_stack[$];
    logic [W-1:0] m_addr;
    logic         m_ovf;
    logic         m_udf;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [OBS-1:0] observed();
        return {ras_underflow, ras_overflow, ras_count, address};
    endfunction

    function automatic logic [OBS-1:0] model_word();
        return {m_udf, m_ovf, CW'(m_stack.size()), m_addr};
    endfunction

    task automatic set_idle();
        enable        = 1'b0;
        ret           = 1'b0;
        call          = 1'b0;
        branch_valid  = 1'b0;
        rel_valid     = 1'b0;
        branch_target = '0;
        rel_offset    = '0;
        clear_flags   = 1'b0;
    endtask

    task automatic model_reset();
        m_stack.delete();
        m_addr = '0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    // Drive one cycle, check next_address combinationally, queue the expected
    // registered state, then compare it after the rising edge.
    task automatic step(input string tag, input logic en, input logic r, input logic c,
                        input logic b, input logic rv, input logic [W-1:0] tgt,
                        input logic [W-1:0] off, input logic clr);
        logic [W-1:0] nxt;
        logic         ev_o;
        logic         ev_u;
        @(negedge clk);
        enable        = en;
        ret           = r;
        call          = c;
        branch_valid  = b;
        rel_valid     = rv;
        branch_target = tgt;
        rel_offset    = off;
        clear_flags   = clr;
        ev_o = 1'b0;
        ev_u = 1'b0;
        if (r) begin
            if (m_stack.size() > 0) nxt = m_stack[$];
            else begin
                nxt  = m_addr + 32'd4;
                ev_u = 1'b1;
            end
        end else if (c) begin
            nxt  = tgt;
            ev_o = (m_stack.size() == 4);
        end else if (b) begin
            nxt = tgt;
        end else if (rv) begin
            nxt = m_addr + off;
        end else begin
            nxt = m_addr + 32'd4;
        end
        #1;
        check({tag, "/next"}, 64'(next_address), 64'(nxt));
        if (en) begin
            if (r) begin
                if (m_stack.size() > 0) void'(m_stack.pop_back());
            end else if (c) begin
                if (ev_o) void'(m_stack.pop_front());
                m_stack.push_back(m_addr + 32'd4);
            end
            m_addr = nxt;
        end else begin
            ev_o = 1'b0;
            ev_u = 1'b0;
        end
        m_ovf = ev_o | (m_ovf & ~clr);
        m_udf = ev_u | (m_udf & ~clr);
        exp_q.push_back(model_word());
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check(tag_q.pop_front(), 64'(observed()), 64'(exp_q.pop_front()));
    endtask

    task automatic seq(input string tag);
        step(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic hold(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic branch(input string tag, input logic [W-1:0] tgt);
        step(tag, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, tgt, '0, 1'b0);
    endtask

    task automatic do_call(input string tag, input logic [W-1:0] tgt);
        step(tag, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, tgt, '0, 1'b0);
    endtask

    task automatic do_ret(input string tag);
        step(tag, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        set_idle();
        model_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 64'(observed()), 64'(model_word()));
        @(negedge clk);
        reset = 1'b1;

        // sequential advance and hold
        for (int i = 0; i < 4; i++) seq($sformatf("seq_%0d", i));
        hold("hold_0");
        hold("hold_1");

        // wraparound and negative relative offset
        branch("br_top", 32'hFFFF_FFFC);
        seq("seq_wrap");
        branch("br_100", 32'h0000_0100);
        step("rel_neg8", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0, 32'hFFFF_FFF8, 1'b0);
        step("rel_rand", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0, W'($urandom_range(0, 255)) << 2, 1'b0);

        // single call/return
        branch("br_40", 32'h40);
        do_call("call_200", 32'h200);
        do_ret("ret_44");

        // nested calls overflow, returns drain then underflow
        branch("br_10", 32'h10);
        for (int i = 0; i < 5; i++) do_call($sformatf("ncall_%0d", i), W'(32'h20 + 32'h10 * i));
        for (int i = 0; i < 5; i++) do_ret($sformatf("nret_%0d", i));
        step("clr_disabled", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        step("ret_hold_dis", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

        // priority: ret beats everything, branch beats relative
        do_call("call_500", 32'h500);
        step("all_ctrl", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h700, 32'h10, 1'b0);
        step("br_rel", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h800, 32'h10, 1'b0);
        step("call_br", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h900, 32'h10, 1'b0);
        do_ret("ret_804");

        // asynchronous reset mid call sequence
        do_ret("udf_set");
        do_call("call_280", 32'h280);
        do_call("call_300", 32'h300);
        @(negedge clk);
        enable        = 1'b1;
        call          = 1'b1;
        branch_target = 32'h999;
        reset         = 1'b0;
        model_reset();
        #1;
        check("async_reset", 64'(observed()), 64'(model_word()));
        @(posedge clk);
        #1;
        check("reset_held", 64'(observed()), 64'(model_word()));
        @(negedge clk);
        set_idle();
        reset = 1'b1;
        seq("post_reset");

        // clear coinciding with a new underflow keeps the flag
        step("clr_vs_udf", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        step("clr_only", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);

        @(negedge clk);
        set_idle();
        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program counter that replaces the fixed 4-bit, increment-only counter.
- Supports configurable address width and step, stall, absolute branch, PC-relative jump, and call/return through an internal return-address stack (RAS).
- Sits at the front of the fetch path and drives the instruction-memory address.
- Control inputs come from the decode/branch-resolution logic.

Parameters:
ADDR_WIDTH, 32, width of address and all address-carrying ports
STEP, 4, sequential increment added each enabled cycle
RESET_ADDR, 0, value loaded into address on reset
RAS_DEPTH, 4, number of return-address stack entries (power of 2, >=2)

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low; address=RESET_ADDR, stack emptied, flags cleared
enable  input  1  1 = advance this cycle; 0 = hold all state, ignore all control inputs
branch_valid  input  1  load branch_target as next address
branch_target  input  ADDR_WIDTH  absolute target for branch/call
rel_valid  input  1  next address = address + rel_offset
rel_offset  input  ADDR_WIDTH  two's-complement signed offset
call  input  1  push address+STEP onto RAS, jump to branch_target (branch_valid not required)
ret  input  1  pop RAS top into address
clear_flags  input  1  synchronous clear of sticky flags (when enable irrelevant)
address  output  ADDR_WIDTH  current PC, registered
next_address  output  ADDR_WIDTH  combinational value address will take at next enabled edge
ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries
ras_overflow  output  1  sticky: push occurred while full
ras_underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (reset=0, asynchronous): address=RESET_ADDR, ras_count=0, both flags=0; stack contents don't-care. Deassertion takes effect at the next rising clk.
- Reset mid-operation: pending control inputs are discarded. First enabled edge after release yields RESET_ADDR+STEP, or the target of whatever control input is active then.
- Update occurs only on a rising clk with enable=1, one cycle latency; address is registered, next_address is combinational.
- Priority when several controls are asserted, highest first:
  - ret: address=top; ras_count-1.
  - call: push address+STEP; address=branch_target.
  - branch_valid: address=branch_target.
  - rel_valid: address=address+rel_offset.
  - none: address=address+STEP.
- Lower-priority inputs are ignored entirely; e.g. ret+call gives pop only, no push.
- Arithmetic: all sums truncated modulo 2^ADDR_WIDTH, no carry-out or flag. rel_offset is sign-interpreted; adding all-ones decrements by 1.
- RAS is a circular buffer with a top pointer.
  - Push when full (ras_count==RAS_DEPTH): overwrite the oldest entry, ras_count stays RAS_DEPTH, ras_overflow<=1.
  - Pop when empty: address=address+STEP (sequential fallback), ras_count stays 0, ras_underflow<=1.
- The flags are sticky until clear_flags=1 at a clock edge, or reset. If clear_flags and a new overflow/underflow event coincide, the flag is set (set wins).
- enable=0: address, stack, ras_count unchanged; clear_flags still honoured. next_address still reflects the current inputs.
- No X propagation: control inputs are sampled only when enable=1.

Decomposition:
- Shared package pc_pkg:
  - control-priority encoding enum (PC_RET, PC_CALL, PC_BRANCH, PC_REL, PC_SEQ)
  - default STEP and RESET_ADDR constants
  - RAS count-width helper function
- One natural sub-module, pc_return_stack: push/pop/data ports, circular storage, count, overflow/underflow event outputs, same clk/reset. pc_sequencer owns the next-address mux and the sticky flags.

Test Plan:
1. Reset release, ADDR_WIDTH=32, STEP=4, enable=1 for 4 cycles -> address 0,4,8,12,16; enable=0 for 2 cycles -> holds 16.
2. address=0xFFFFFFFC, sequential step -> 0x00000000. Then rel_valid, rel_offset=0xFFFFFFF8 from 0x100 -> 0xF8.
3. At address 0x40, call with branch_target=0x200 -> address 0x200, ras_count=1. Next cycle ret -> address 0x44, ras_count=0.
4. RAS_DEPTH=4, five nested calls from 0x10,0x20,0x30,0x40,0x50 -> ras_overflow=1, count=4. Four rets -> 0x54,0x44,0x34,0x24; fifth ret -> sequential +4, ras_underflow=1.
5. ret, call, branch_valid, rel_valid all asserted with count=1 -> only pop applied, count 0, no push. branch_valid+rel_valid -> branch_target taken.
6. Assert reset low asynchronously mid-call sequence at address 0x300, count=2 -> address=0 immediately (before next edge), count=0, flags=0. clear_flags coincident with new underflow -> ras_underflow=1.
